// File: rtl/serv_bus_arb_sram.sv
// rtl/serv_bus_arb_sram.sv - SERV ibus/dbus arbiter onto one synchronous single-port SRAM
`timescale 1ns/1ps
module serv_bus_arb_sram #(
  parameter int AW     = 12,
  parameter int RD_LAT = 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [31:0]   i_ibus_adr,
  input  logic          i_ibus_cyc,
  output logic [31:0]   o_ibus_rdt,
  output logic          o_ibus_ack,
  input  logic [31:0]   i_dbus_adr,
  input  logic [31:0]   i_dbus_dat,
  input  logic [3:0]    i_dbus_sel,
  input  logic          i_dbus_we,
  input  logic          i_dbus_cyc,
  output logic [31:0]   o_dbus_rdt,
  output logic          o_dbus_ack,
  output logic [AW-1:0] o_mem_addr,
  output logic          o_mem_en,
  output logic [3:0]    o_mem_we,
  output logic [31:0]   o_mem_wdata,
  input  logic [31:0]   i_mem_rdata
);

  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
    $error("serv_bus_arb_sram: RD_LAT must be in 1..4");
  end
  if (AW < 1 || AW > 29) begin : g_bad_aw
    $error("serv_bus_arb_sram: AW must be in 1..29");
  end

  localparam logic [1:0] LAT_M1 = 2'(RD_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

  state_t      state, state_nxt;
  logic        gnt_d, req_we, req_map;
  logic [1:0]  cnt;

  // Arbitration view of the request presented this cycle; dbus has priority
  logic        grant_d;
  logic [31:2] gnt_adr;
  logic        gnt_we;
  logic        gnt_map;
  logic        any_req;
  logic        unused_adr_lsb;

  assign grant_d        = i_dbus_cyc;
  assign any_req        = i_dbus_cyc | i_ibus_cyc;
  assign gnt_adr        = grant_d ? i_dbus_adr[31:2] : i_ibus_adr[31:2];
  assign gnt_we         = grant_d & i_dbus_we;
  assign gnt_map        = (gnt_adr[31:AW+2] == '0);
  assign unused_adr_lsb = ^{i_ibus_adr[1:0], i_dbus_adr[1:0]};

  // Next values of the registered outputs
  logic          iack_nxt, dack_nxt, mem_en_nxt;
  logic [31:0]   irdt_nxt, drdt_nxt, mem_wdata_nxt, rd_data;
  logic [3:0]    mem_we_nxt;
  logic [AW-1:0] mem_addr_nxt;

  // State register plus the context of the granted access and the latency counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= S_IDLE;
      gnt_d   <= 1'b0;
      req_we  <= 1'b0;
      req_map <= 1'b0;
      cnt     <= 2'd0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE) begin
        gnt_d   <= grant_d;
        req_we  <= gnt_we;
        req_map <= gnt_map;
      end
      if (state == S_ISSUE) cnt <= 2'd0;
      else if (state == S_WAIT) cnt <= cnt + 2'd1;
    end
  end

  // Next-state logic; a granted access always runs through to its ack
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (any_req) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = (req_map && !req_we) ? S_WAIT : S_ACK;
      S_WAIT:  if (cnt == LAT_M1) state_nxt = S_ACK;
      S_ACK:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic: SRAM strobe is prepared on grant, ack and read data on entry to ACK
  always_comb begin
    iack_nxt      = 1'b0;
    dack_nxt      = 1'b0;
    mem_en_nxt    = 1'b0;
    mem_we_nxt    = 4'b0;
    mem_addr_nxt  = o_mem_addr;
    mem_wdata_nxt = o_mem_wdata;
    irdt_nxt      = o_ibus_rdt;
    drdt_nxt      = o_dbus_rdt;
    rd_data       = (state == S_WAIT) ? i_mem_rdata : 32'h0;
    if (state == S_IDLE && any_req && gnt_map) begin
      mem_en_nxt   = 1'b1;
      mem_we_nxt   = gnt_we ? i_dbus_sel : 4'b0;
      mem_addr_nxt = gnt_adr[AW+1:2];
      if (grant_d) mem_wdata_nxt = i_dbus_dat;
    end
    if (state != S_ACK && state_nxt == S_ACK) begin
      if (gnt_d) dack_nxt = 1'b1;
      else       iack_nxt = 1'b1;
      if (!req_we) begin
        if (gnt_d) drdt_nxt = rd_data;
        else       irdt_nxt = rd_data;
      end
    end
  end

  // Output registers; an access cut short by reset never produces an ack
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ibus_ack  <= 1'b0;
      o_dbus_ack  <= 1'b0;
      o_ibus_rdt  <= 32'h0;
      o_dbus_rdt  <= 32'h0;
      o_mem_en    <= 1'b0;
      o_mem_we    <= 4'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= 32'h0;
    end else begin
      o_ibus_ack  <= iack_nxt;
      o_dbus_ack  <= dack_nxt;
      o_ibus_rdt  <= irdt_nxt;
      o_dbus_rdt  <= drdt_nxt;
      o_mem_en    <= mem_en_nxt;
      o_mem_we    <= mem_we_nxt;
      o_mem_addr  <= mem_addr_nxt;
      o_mem_wdata <= mem_wdata_nxt;
    end
  end

endmodule

// File: tb/tb_serv_bus_arb_sram.sv
// tb/tb_serv_bus_arb_sram.sv - directed bench for serv_bus_arb_sram (RD_LAT=1 and RD_LAT=4 instances)
`timescale 1ns/1ps
module tb_serv_bus_arb_sram;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] ibus_adr [2];
  logic        ibus_cyc [2];
  logic [31:0] ibus_rdt [2];
  logic        ibus_ack [2];
  logic [31:0] dbus_adr [2];
  logic [31:0] dbus_dat [2];
  logic [3:0]  dbus_sel [2];
  logic        dbus_we  [2];
  logic        dbus_cyc [2];
  logic [31:0] dbus_rdt [2];
  logic        dbus_ack [2];
  logic [11:0] mem_addr [2];
  logic        mem_en   [2];
  logic [3:0]  mem_we   [2];
  logic [31:0] mem_wdata[2];
  logic [31:0] mem_rdata[2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 4;
    logic [31:0] mem  [0:4095];
    logic [31:0] pipe [0:3];
    int en_cnt = 0;
    int iack_cnt = 0;
    int dack_cnt = 0;

    serv_bus_arb_sram #(.AW(12), .RD_LAT(LAT)) u_dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_ibus_adr  (ibus_adr[g]),
      .i_ibus_cyc  (ibus_cyc[g]),
      .o_ibus_rdt  (ibus_rdt[g]),
      .o_ibus_ack  (ibus_ack[g]),
      .i_dbus_adr  (dbus_adr[g]),
      .i_dbus_dat  (dbus_dat[g]),
      .i_dbus_sel  (dbus_sel[g]),
      .i_dbus_we   (dbus_we[g]),
      .i_dbus_cyc  (dbus_cyc[g]),
      .o_dbus_rdt  (dbus_rdt[g]),
      .o_dbus_ack  (dbus_ack[g]),
      .o_mem_addr  (mem_addr[g]),
      .o_mem_en    (mem_en[g]),
      .o_mem_we    (mem_we[g]),
      .o_mem_wdata (mem_wdata[g]),
      .i_mem_rdata (mem_rdata[g])
    );

    initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 32'hA5A5_0000 | i;
      mem[4] = 32'hDEAD_BEEF;
      for (int k = 0; k < 4; k++) pipe[k] = 32'h0BAD_F00D;
    end

    // SRAM model: read data appears LAT cycles after the strobe, garbage otherwise
    always @(posedge clk) begin
      if (mem_en[g])
        for (int b = 0; b < 4; b++)
          if (mem_we[g][b]) mem[mem_addr[g]][8*b +: 8] <= mem_wdata[g][8*b +: 8];
      pipe[0] <= mem_en[g] ? mem[mem_addr[g]] : 32'h0BAD_F00D;
      for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
    end
    assign mem_rdata[g] = pipe[LAT-1];

    always @(negedge clk) begin
      if (mem_en[g])   en_cnt++;
      if (ibus_ack[g]) iack_cnt++;
      if (dbus_ack[g]) dack_cnt++;
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One Wishbone access; lat counts edges from cyc-high to the ack cycle
  task automatic access(input int d, input bit isd, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input bit we, output int lat, output logic en1,
                        output logic [3:0] we1, output logic [11:0] addr1);
    logic ack;
    if (isd) begin
      dbus_adr[d] = adr; dbus_dat[d] = dat; dbus_sel[d] = sel; dbus_we[d] = we; dbus_cyc[d] = 1'b1;
    end else begin
      ibus_adr[d] = adr; ibus_cyc[d] = 1'b1;
    end
    lat = 0; en1 = 1'b0; we1 = 4'b0; addr1 = 12'h0;
    while (lat < 20) begin
      tick();
      lat++;
      if (lat == 1) begin en1 = mem_en[d]; we1 = mem_we[d]; addr1 = mem_addr[d]; end
      ack = isd ? dbus_ack[d] : ibus_ack[d];
      if (ack) break;
    end
    dbus_cyc[d] = 1'b0; dbus_we[d] = 1'b0; ibus_cyc[d] = 1'b0;
    tick();
  endtask

  int          lat, base_i, base_d, base_e, dcyc, icyc;
  logic        en1, en5;
  logic [3:0]  we1;
  logic [11:0] a1, c1_addr, c5_addr;

  initial begin
    for (int d = 0; d < 2; d++) begin
      ibus_adr[d] = 0; ibus_cyc[d] = 0; dbus_adr[d] = 0; dbus_dat[d] = 0;
      dbus_sel[d] = 0; dbus_we[d] = 0; dbus_cyc[d] = 0;
    end
    repeat (3) tick();
    check("rst ibus_ack", 32'(ibus_ack[0]), 32'h0);
    check("rst dbus_ack", 32'(dbus_ack[0]), 32'h0);
    check("rst ibus_rdt", ibus_rdt[0], 32'h0);
    check("rst dbus_rdt", dbus_rdt[0], 32'h0);
    check("rst mem_en", 32'(mem_en[0]), 32'h0);
    check("rst mem_we", 32'(mem_we[0]), 32'h0);
    check("rst mem_addr", 32'(mem_addr[0]), 32'h0);
    check("rst mem_wdata", mem_wdata[0], 32'h0);
    rst_n = 1'b1;
    tick();

    // ibus read, RD_LAT=1
    access(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, lat, en1, we1, a1);
    check("t1 latency", 32'(lat), 32'd3);
    check("t1 mem_en", 32'(en1), 32'h1);
    check("t1 mem_addr", 32'(a1), 32'h4);
    check("t1 mem_we", 32'(we1), 32'h0);
    check("t1 ibus_rdt", ibus_rdt[0], 32'hDEAD_BEEF);
    check("t1 iack count", 32'(g_dut[0].iack_cnt), 32'd1);
    check("t1 no dbus ack", 32'(g_dut[0].dack_cnt), 32'd0);

    // partial dbus write then readback
    access(0, 1'b1, 32'h20, 32'h1234_5678, 4'b0011, 1'b1, lat, en1, we1, a1);
    check("t2 wr latency", 32'(lat), 32'd2);
    check("t2 wr mem_en", 32'(en1), 32'h1);
    check("t2 wr mem_we", 32'(we1), 32'h3);
    check("t2 wr mem_addr", 32'(a1), 32'h8);
    check("t2 wr mem_wdata", mem_wdata[0], 32'h1234_5678);
    check("t2 wr rdt held", dbus_rdt[0], 32'h0);
    access(0, 1'b1, 32'h20, 32'h0, 4'hF, 1'b0, lat, en1, we1, a1);
    check("t2 rd latency", 32'(lat), 32'd3);
    check("t2 rd mem_we", 32'(we1), 32'h0);
    check("t2 readback", dbus_rdt[0], 32'hA5A5_5678);

    // unmapped read and write
    base_e = g_dut[0].en_cnt;
    access(0, 1'b1, 32'h0000_4000, 32'h0, 4'hF, 1'b0, lat, en1, we1, a1);
    check("t4 rd latency", 32'(lat), 32'd2);
    check("t4 rd mem_en", 32'(en1), 32'h0);
    check("t4 rd rdt zero", dbus_rdt[0], 32'h0);
    access(0, 1'b1, 32'h0000_4000, 32'hFFFF_FFFF, 4'hF, 1'b1, lat, en1, we1, a1);
    check("t4 wr latency", 32'(lat), 32'd2);
    check("t4 wr mem_we", 32'(we1), 32'h0);
    check("t4 no mem_en", 32'(g_dut[0].en_cnt - base_e), 32'd0);

    // simultaneous requests: dbus first, ibus re-arbitrated after dbus ack
    base_i = g_dut[0].iack_cnt; base_d = g_dut[0].dack_cnt; base_e = g_dut[0].en_cnt;
    dbus_adr[0] = 32'h10; dbus_sel[0] = 4'hF; dbus_we[0] = 1'b0; dbus_cyc[0] = 1'b1;
    ibus_adr[0] = 32'h20; ibus_cyc[0] = 1'b1;
    dcyc = 0; icyc = 0; en5 = 1'b0; c1_addr = 12'h0; c5_addr = 12'h0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 1) c1_addr = mem_addr[0];
      if (c == 5) begin c5_addr = mem_addr[0]; en5 = mem_en[0]; end
      if (dbus_ack[0] && dcyc == 0) begin dcyc = c; dbus_cyc[0] = 1'b0; end
      if (ibus_ack[0] && icyc == 0) begin icyc = c; ibus_cyc[0] = 1'b0; end
    end
    dbus_cyc[0] = 1'b0; ibus_cyc[0] = 1'b0;
    check("t3 first addr", 32'(c1_addr), 32'h4);
    check("t3 dbus ack cycle", 32'(dcyc), 32'd3);
    check("t3 ibus en after dack", 32'(en5), 32'h1);
    check("t3 ibus addr", 32'(c5_addr), 32'h8);
    check("t3 ibus ack cycle", 32'(icyc), 32'd7);
    check("t3 dbus_rdt", dbus_rdt[0], 32'hDEAD_BEEF);
    check("t3 ibus_rdt", ibus_rdt[0], 32'hA5A5_5678);
    check("t3 one dbus ack", 32'(g_dut[0].dack_cnt - base_d), 32'd1);
    check("t3 one ibus ack", 32'(g_dut[0].iack_cnt - base_i), 32'd1);
    check("t3 two mem_en", 32'(g_dut[0].en_cnt - base_e), 32'd2);

    // RD_LAT=4 back-to-back ibus reads
    base_e = g_dut[1].en_cnt;
    access(1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, lat, en1, we1, a1);
    check("t5 rd0 latency", 32'(lat), 32'd6);
    check("t5 rd0 data", ibus_rdt[1], 32'hA5A5_0000);
    access(1, 1'b0, 32'h4, 32'h0, 4'h0, 1'b0, lat, en1, we1, a1);
    check("t5 rd1 latency", 32'(lat), 32'd6);
    check("t5 rd1 data", ibus_rdt[1], 32'hA5A5_0001);
    check("t5 mem_en count", 32'(g_dut[1].en_cnt - base_e), 32'd2);

    // reset while the RD_LAT=1 instance is in WAIT
    base_d = g_dut[0].dack_cnt;
    dbus_adr[0] = 32'h10; dbus_sel[0] = 4'hF; dbus_we[0] = 1'b0; dbus_cyc[0] = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("t6 mem_addr", 32'(mem_addr[0]), 32'h0);
    check("t6 dbus_rdt", dbus_rdt[0], 32'h0);
    check("t6 ibus_rdt", ibus_rdt[0], 32'h0);
    check("t6 mem_en", 32'(mem_en[0]), 32'h0);
    check("t6 dbus_ack", 32'(dbus_ack[0]), 32'h0);
    dbus_cyc[0] = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("t6 no ack", 32'(g_dut[0].dack_cnt - base_d), 32'd0);
    access(0, 1'b1, 32'h20, 32'h0, 4'hF, 1'b0, lat, en1, we1, a1);
    check("t6 post latency", 32'(lat), 32'd3);
    check("t6 post data", dbus_rdt[0], 32'hA5A5_5678);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
